// File: rtl/wb_sequencer_if.sv
// Bus bundle between the instruction decoder / memory side and wb_sequencer.
// slave  : the sequencer (consumes instructions and memory acks, drives
//          the write-back select, register-file strobes and memory requests).
// master : the surrounding datapath / test environment.
interface wb_sequencer_if;
  logic       i_InstValid;
  logic       o_InstReady;
  logic [2:0] i_Opcode;
  logic [2:0] i_Rd;
  logic       i_MemAck;
  logic       o_RdReq;
  logic       o_WrReq;
  logic [2:0] o_Sel_Mux;
  logic       o_RegWe;
  logic [2:0] o_RegAddr;
  logic       o_PcLoad;
  logic       o_Halted;
  logic       o_Error;

  modport slave (
    input  i_InstValid, i_Opcode, i_Rd, i_MemAck,
    output o_InstReady, o_RdReq, o_WrReq, o_Sel_Mux, o_RegWe,
           o_RegAddr, o_PcLoad, o_Halted, o_Error
  );

  modport master (
    output i_InstValid, i_Opcode, i_Rd, i_MemAck,
    input  o_InstReady, o_RdReq, o_WrReq, o_Sel_Mux, o_RegWe,
           o_RegAddr, o_PcLoad, o_Halted, o_Error
  );
endinterface

// File: rtl/wb_sequencer.sv
// Write-back sequencer for the MicroUAZ datapath.
// Accepts decoded instructions over a valid/ready handshake, drives the
// write-back Mux select, register-file write enable/address, the CALL
// PC-load pulse and the memory read/write request handshakes with a
// bounded wait for the memory acknowledge.
// Ports:
//   i_Clk   : clock, rising edge
//   i_Reset : synchronous, active-high reset
//   bus     : wb_sequencer_if.slave (instruction handshake, memory
//             handshake, write-back controls, halted / sticky error flags)
// All outputs are registered.
module wb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 8
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  wb_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_MOVY = 3'b001,
    OP_MOVX = 3'b010,
    OP_LDI  = 3'b011,
    OP_LD   = 3'b100,
    OP_CALL = 3'b101,
    OP_ST   = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  localparam logic [2:0] SEL_DATAIN = 3'b000;
  localparam logic [2:0] SEL_RY     = 3'b001;
  localparam logic [2:0] SEL_RX     = 3'b010;
  localparam logic [2:0] SEL_NUM    = 3'b011;
  localparam logic [2:0] SEL_SAVER7 = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  opcode_t          op_q;
  logic [2:0]       rd_q;
  logic [CNT_W-1:0] cnt;

  logic       inst_ready;
  logic       rd_req;
  logic       wr_req;
  logic [2:0] sel_mux;
  logic       reg_we;
  logic [2:0] reg_addr;
  logic       pc_load;
  logic       halted;
  logic       error;

  // An ack only counts while a request is actually on the bus.
  logic mem_ack_valid;
  assign mem_ack_valid = bus.i_MemAck && (rd_req || wr_req);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      rd_q       <= '0;
      cnt        <= '0;
      inst_ready <= 1'b1;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      sel_mux    <= '0;
      reg_we     <= 1'b0;
      reg_addr   <= '0;
      pc_load    <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      pc_load <= 1'b0;

      case (state)
        S_IDLE: begin
          inst_ready <= 1'b1;
          if (bus.i_InstValid && inst_ready) begin
            op_q       <= opcode_t'(bus.i_Opcode);
            rd_q       <= bus.i_Rd;
            inst_ready <= 1'b0;
            state      <= S_DECODE;
          end
        end

        S_DECODE: begin
          reg_addr <= rd_q;
          case (op_q)
            OP_NOP:  state <= S_IDLE;
            OP_MOVY: begin sel_mux <= SEL_RY;  state <= S_WB; end
            OP_MOVX: begin sel_mux <= SEL_RX;  state <= S_WB; end
            OP_LDI:  begin sel_mux <= SEL_NUM; state <= S_WB; end
            OP_LD:   begin sel_mux <= SEL_DATAIN; state <= S_MEM_RD; end
            OP_CALL: begin
              sel_mux  <= SEL_SAVER7;
              reg_addr <= 3'd7;
              state    <= S_WB;
            end
            OP_ST:   state <= S_MEM_WR;
            OP_HALT: state <= S_HALT;
            default: state <= S_IDLE;
          endcase
        end

        S_MEM_RD, S_MEM_WR: begin
          if (mem_ack_valid) begin
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            cnt    <= '0;
            if (state == S_MEM_RD) begin
              // Read data is on DataInBus only in the cycle right after the
              // ack, so the load's write strobe fires here and WB just
              // retires it.
              reg_we <= 1'b1;
              state  <= S_WB;
            end else begin
              state  <= S_IDLE;
            end
          end else if (cnt == CNT_LIMIT) begin
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            cnt    <= '0;
            error  <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            rd_req <= (state == S_MEM_RD);
            wr_req <= (state == S_MEM_WR);
          end
        end

        S_WB: begin
          reg_we  <= (op_q != OP_LD);
          pc_load <= (op_q == OP_CALL);
          state   <= S_IDLE;
        end

        S_HALT: begin
          halted     <= 1'b1;
          inst_ready <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_InstReady = inst_ready;
  assign bus.o_RdReq     = rd_req;
  assign bus.o_WrReq     = wr_req;
  assign bus.o_Sel_Mux   = sel_mux;
  assign bus.o_RegWe     = reg_we;
  assign bus.o_RegAddr   = reg_addr;
  assign bus.o_PcLoad    = pc_load;
  assign bus.o_Halted    = halted;
  assign bus.o_Error     = error;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer. Cycle n is the period following clock
// edge n, where edge 0 is the instruction accept edge.
module tb_wb_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_sequencer_if bus ();

  wb_sequencer #(
    .TIMEOUT_CYCLES (15),
    .CNT_W          (8)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {WrReq, RdReq, RegWe}
  function automatic logic [2:0] strobes();
    return {bus.o_WrReq, bus.o_RdReq, bus.o_RegWe};
  endfunction

  task automatic drive(input logic valid, input logic [2:0] op, input logic [2:0] rd);
    bus.i_InstValid = valid;
    bus.i_Opcode    = op;
    bus.i_Rd        = rd;
  endtask

  logic [2:0] b2b_op   [3];
  logic [2:0] b2b_rd   [3];
  logic [2:0] b2b_sel  [3];
  logic [2:0] b2b_addr [3];
  logic       b2b_pc   [3];

  initial begin
    b2b_op   = '{3'b011, 3'b010, 3'b101};
    b2b_rd   = '{3'd1,   3'd2,   3'd5};
    b2b_sel  = '{3'b011, 3'b010, 3'b100};
    b2b_addr = '{3'd1,   3'd2,   3'd7};
    b2b_pc   = '{1'b0,   1'b0,   1'b1};

    rst          = 1'b1;
    bus.i_MemAck = 1'b0;
    drive(1'b0, 3'b000, 3'd0);
    tick();
    tick();

    // Reset values
    check("rst_ready",  {7'd0, bus.o_InstReady}, 8'd1);
    check("rst_sel",    {5'd0, bus.o_Sel_Mux},   8'd0);
    check("rst_addr",   {5'd0, bus.o_RegAddr},   8'd0);
    check("rst_strobe", {5'd0, strobes()},       8'd0);
    check("rst_flags",  {5'd0, bus.o_PcLoad, bus.o_Halted, bus.o_Error}, 8'd0);
    rst = 1'b0;

    // MOVY rd=3
    drive(1'b1, 3'b001, 3'd3);
    tick();                                         // cycle 0
    drive(1'b0, 3'b000, 3'd0);
    check("movy_c0_ready", {7'd0, bus.o_InstReady}, 8'd0);
    tick();                                         // cycle 1
    check("movy_c1_sel",   {5'd0, bus.o_Sel_Mux},   8'd1);
    check("movy_c1_we",    {7'd0, bus.o_RegWe},     8'd0);
    tick();                                         // cycle 2
    check("movy_c2_we",    {7'd0, bus.o_RegWe},     8'd1);
    check("movy_c2_addr",  {5'd0, bus.o_RegAddr},   8'd3);
    check("movy_c2_sel",   {5'd0, bus.o_Sel_Mux},   8'd1);
    check("movy_c2_ready", {7'd0, bus.o_InstReady}, 8'd0);
    tick();                                         // cycle 3
    check("movy_c3_we",    {7'd0, bus.o_RegWe},     8'd0);
    check("movy_c3_ready", {7'd0, bus.o_InstReady}, 8'd1);

    // Back-to-back LDI rd=1, MOVX rd=2, CALL rd=5 with valid held high
    drive(1'b1, b2b_op[0], b2b_rd[0]);
    for (int i = 0; i < 3; i++) begin
      tick();                                       // accept
      if (i < 2) drive(1'b1, b2b_op[i+1], b2b_rd[i+1]);
      else       drive(1'b0, 3'b000, 3'd0);
      check($sformatf("b2b%0d_c0_pc", i), {7'd0, bus.o_PcLoad}, 8'd0);
      tick();
      check($sformatf("b2b%0d_c1_sel", i), {5'd0, bus.o_Sel_Mux}, {5'd0, b2b_sel[i]});
      check($sformatf("b2b%0d_c1_pc", i),  {7'd0, bus.o_PcLoad},  8'd0);
      tick();
      check($sformatf("b2b%0d_c2_we", i),   {7'd0, bus.o_RegWe},   8'd1);
      check($sformatf("b2b%0d_c2_addr", i), {5'd0, bus.o_RegAddr}, {5'd0, b2b_addr[i]});
      check($sformatf("b2b%0d_c2_pc", i),   {7'd0, bus.o_PcLoad},  {7'd0, b2b_pc[i]});
      tick();
      check($sformatf("b2b%0d_c3_ready", i), {7'd0, bus.o_InstReady}, 8'd1);
      check($sformatf("b2b%0d_c3_pc", i),    {7'd0, bus.o_PcLoad},    8'd0);
    end

    // LD rd=4, ack after three request cycles
    drive(1'b1, 3'b100, 3'd4);
    tick();                                         // cycle 0
    drive(1'b0, 3'b000, 3'd0);
    tick();                                         // cycle 1
    check("ld_c1_strobe", {5'd0, strobes()},     8'd0);
    check("ld_c1_sel",    {5'd0, bus.o_Sel_Mux}, 8'd0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check($sformatf("ld_c%0d_strobe", c), {5'd0, strobes()}, 8'h2);
    end
    tick();                                         // cycle 5: ack
    check("ld_c5_strobe", {5'd0, strobes()}, 8'h2);
    bus.i_MemAck = 1'b1;
    tick();                                         // cycle 6
    bus.i_MemAck = 1'b0;
    check("ld_wb_strobe", {5'd0, strobes()},     8'h1);
    check("ld_wb_sel",    {5'd0, bus.o_Sel_Mux}, 8'd0);
    check("ld_wb_addr",   {5'd0, bus.o_RegAddr}, 8'd4);
    check("ld_wb_err",    {7'd0, bus.o_Error},   8'd0);
    tick();                                         // cycle 7
    check("ld_c7_strobe", {5'd0, strobes()}, 8'd0);
    tick();                                         // cycle 8
    check("ld_c8_ready", {7'd0, bus.o_InstReady}, 8'd1);

    // ST with no ack: times out after 15 request cycles
    drive(1'b1, 3'b110, 3'd0);
    tick();
    drive(1'b0, 3'b000, 3'd0);
    tick();                                         // cycle 1
    for (int c = 2; c <= 16; c++) begin
      tick();
      check($sformatf("st_c%0d_strobe", c), {5'd0, strobes()}, 8'h4);
    end
    tick();                                         // cycle 17
    check("st_to_strobe", {5'd0, strobes()},   8'd0);
    check("st_to_err",    {7'd0, bus.o_Error}, 8'd1);
    tick();                                         // cycle 18
    check("st_to_ready",  {7'd0, bus.o_InstReady}, 8'd1);
    check("st_to_we",     {7'd0, bus.o_RegWe},     8'd0);

    // NOP after timeout: accepted, error stays set
    drive(1'b1, 3'b000, 3'd6);
    tick();
    drive(1'b0, 3'b000, 3'd0);
    check("nop_c0_ready", {7'd0, bus.o_InstReady}, 8'd0);
    tick();
    check("nop_c1_strobe", {5'd0, strobes()}, 8'd0);
    tick();
    check("nop_c2_ready", {7'd0, bus.o_InstReady}, 8'd1);
    check("nop_c2_err",   {7'd0, bus.o_Error},     8'd1);

    // Reset clears the sticky error
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_err", {7'd0, bus.o_Error}, 8'd0);

    // LD rd=6 with ack on the exact timeout cycle: ack wins
    drive(1'b1, 3'b100, 3'd6);
    tick();
    drive(1'b0, 3'b000, 3'd0);
    tick();                                         // cycle 1
    for (int c = 2; c <= 15; c++) begin
      tick();
      check($sformatf("ldb_c%0d_strobe", c), {5'd0, strobes()}, 8'h2);
    end
    tick();                                         // cycle 16: last request cycle
    check("ldb_c16_strobe", {5'd0, strobes()}, 8'h2);
    bus.i_MemAck = 1'b1;
    tick();                                         // cycle 17
    bus.i_MemAck = 1'b0;
    check("ldb_wb_strobe", {5'd0, strobes()},     8'h1);
    check("ldb_wb_addr",   {5'd0, bus.o_RegAddr}, 8'd6);
    check("ldb_wb_err",    {7'd0, bus.o_Error},   8'd0);
    tick();
    tick();
    check("ldb_end_err",   {7'd0, bus.o_Error},       8'd0);
    check("ldb_end_ready", {7'd0, bus.o_InstReady},   8'd1);

    // Reset while in MEM_RD
    drive(1'b1, 3'b100, 3'd2);
    tick();
    drive(1'b0, 3'b000, 3'd0);
    tick();
    tick();                                         // cycle 2
    check("rmr_c2_strobe", {5'd0, strobes()}, 8'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmr_strobe", {5'd0, strobes()},       8'd0);
    check("rmr_ready",  {7'd0, bus.o_InstReady}, 8'd1);
    bus.i_MemAck = 1'b1;                            // stray ack in IDLE
    tick();
    bus.i_MemAck = 1'b0;
    check("rmr_ack_strobe", {5'd0, strobes()}, 8'd0);
    tick();
    check("rmr_ack_strobe2", {5'd0, strobes()}, 8'd0);

    // HALT
    drive(1'b1, 3'b111, 3'd0);
    tick();
    drive(1'b1, 3'b001, 3'd1);                      // keep offering MOVY
    tick();
    tick();                                         // cycle 2
    check("halt_flag",  {7'd0, bus.o_Halted},     8'd1);
    check("halt_ready", {7'd0, bus.o_InstReady},  8'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("halt_hold%0d", c),
            {4'd0, bus.o_Halted, bus.o_InstReady, bus.o_RegWe, bus.o_PcLoad}, 8'h8);
    end
    drive(1'b0, 3'b000, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_rst_flag",  {7'd0, bus.o_Halted},    8'd0);
    check("halt_rst_ready", {7'd0, bus.o_InstReady}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
